// File: rtl/am_bip_calculator_pkg.sv
// Shared constants and types for the per-lane AM BIP calculator.
package am_bip_calculator_pkg;

   localparam int unsigned NB_DATA         = 66;
   localparam int unsigned NB_BIP          = 8;
   localparam int unsigned AM_BLOCK_PERIOD = 16384;
   localparam int unsigned NB_BLOCK_COUNT  = $clog2(AM_BLOCK_PERIOD);

   // Block-bit offsets of the BIP3 and BIP7 fields inside an alignment marker
   localparam int unsigned BIP3_OFFSET = 26;
   localparam int unsigned BIP7_OFFSET = 58;

   typedef enum logic [0:0] {
      WAIT_AM = 1'b0,
      ACCUM   = 1'b1
   } bip_state_t;

endpackage

// File: rtl/am_bip_calculator_bip8_block_parity.sv
// Combinational 66b block -> 8b bit-interleaved parity map.
// Block bit p lives at i_block[NB_DATA-1-p]; bits 0/1 are the sync header.
module am_bip_calculator_bip8_block_parity
   import am_bip_calculator_pkg::*;
(
   input  logic [NB_DATA-1:0] i_block,
   output logic [NB_BIP-1:0]  o_parity
);

   // Bit j covers block bits j+2, j+10, ... j+58; sync header folds into bits 3 and 4
   always_comb begin
      o_parity = '0;
      for (int j = 0; j < 8; j++) begin
         for (int k = 0; k < 8; k++) begin
            o_parity[j] = o_parity[j] ^ i_block[NB_DATA-1-(j+2+8*k)];
         end
      end
      o_parity[3] = o_parity[3] ^ i_block[NB_DATA-1];
      o_parity[4] = o_parity[4] ^ i_block[NB_DATA-2];
   end

endmodule

// File: rtl/am_bip_calculator.sv
// Per-lane BIP3 accumulator between alignment markers, with received/calculated
// BIP report, BIP7 consistency flag and missing-AM detection.
module am_bip_calculator
   import am_bip_calculator_pkg::*;
(
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_am_flag,
   output logic [NB_BIP-1:0]  o_recived_bip,
   output logic [NB_BIP-1:0]  o_calculated_bip,
   output logic               o_match,
   output logic               o_bip7_error,
   output logic               o_am_missing
);

   localparam logic [NB_BLOCK_COUNT-1:0] LAST_COUNT = NB_BLOCK_COUNT'(AM_BLOCK_PERIOD - 1);

   bip_state_t                state;
   logic [NB_BIP-1:0]         acc;
   logic [NB_BLOCK_COUNT-1:0] cnt;
   logic [NB_BIP-1:0]         block_bip_c;
   logic [NB_BIP-1:0]         bip3_field_c;
   logic [NB_BIP-1:0]         bip7_field_c;
   logic                      accept_c;

   am_bip_calculator_bip8_block_parity u_block_parity (
      .i_block  (i_data),
      .o_parity (block_bip_c)
   );

   // Field bit j is block bit offset+j
   always_comb begin
      bip3_field_c = '0;
      bip7_field_c = '0;
      for (int j = 0; j < 8; j++) begin
         bip3_field_c[j] = i_data[NB_DATA-1-BIP3_OFFSET-j];
         bip7_field_c[j] = i_data[NB_DATA-1-BIP7_OFFSET-j];
      end
   end

   assign accept_c = i_enable & i_valid;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state            <= WAIT_AM;
         acc              <= '0;
         cnt              <= '0;
         o_recived_bip    <= '0;
         o_calculated_bip <= '0;
         o_match          <= 1'b0;
         o_bip7_error     <= 1'b0;
         o_am_missing     <= 1'b0;
      end else begin
         o_match      <= 1'b0;
         o_bip7_error <= 1'b0;
         o_am_missing <= 1'b0;
         if (accept_c) begin
            case (state)
               WAIT_AM: begin
                  if (i_am_flag) begin
                     acc   <= block_bip_c;
                     cnt   <= '0;
                     state <= ACCUM;
                  end
               end
               ACCUM: begin
                  if (i_am_flag) begin
                     // The new period starts with, and includes, this AM
                     o_calculated_bip <= acc;
                     o_recived_bip    <= bip3_field_c;
                     o_match          <= 1'b1;
                     o_bip7_error     <= (bip7_field_c != ~bip3_field_c);
                     acc              <= block_bip_c;
                     cnt              <= '0;
                  end else if (cnt == LAST_COUNT) begin
                     o_am_missing <= 1'b1;
                     acc          <= '0;
                     cnt          <= '0;
                     state        <= WAIT_AM;
                  end else begin
                     acc <= acc ^ block_bip_c;
                     cnt <= cnt + NB_BLOCK_COUNT'(1);
                  end
               end
               default: state <= WAIT_AM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_am_bip_calculator.sv
// Directed self-checking bench for am_bip_calculator.
module tb_am_bip_calculator;
   import am_bip_calculator_pkg::*;

   logic               i_clock = 1'b0;
   logic               i_reset;
   logic               i_enable;
   logic               i_valid;
   logic [NB_DATA-1:0] i_data;
   logic               i_am_flag;
   logic [NB_BIP-1:0]  o_recived_bip;
   logic [NB_BIP-1:0]  o_calculated_bip;
   logic               o_match;
   logic               o_bip7_error;
   logic               o_am_missing;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned strobe_seen;

   am_bip_calculator dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_enable         (i_enable),
      .i_valid          (i_valid),
      .i_data           (i_data),
      .i_am_flag        (i_am_flag),
      .o_recived_bip    (o_recived_bip),
      .o_calculated_bip (o_calculated_bip),
      .o_match          (o_match),
      .o_bip7_error     (o_bip7_error),
      .o_am_missing     (o_am_missing)
   );

   always #5 i_clock = ~i_clock;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SH=01, given BIP3/BIP7 fields, optional single flipped block bit (flip<0 means none)
   function automatic logic [NB_DATA-1:0] make_block(input logic [7:0] bip3, input logic [7:0] bip7,
                                                     input int flip);
      logic [NB_DATA-1:0] d;
      d = '0;
      d[NB_DATA-2] = 1'b1;
      for (int j = 0; j < 8; j++) begin
         d[NB_DATA-1-26-j] = bip3[j];
         d[NB_DATA-1-58-j] = bip7[j];
      end
      if (flip >= 0) d[NB_DATA-1-flip] = ~d[NB_DATA-1-flip];
      return d;
   endfunction

   // Drive one cycle of inputs and sample 1 time unit after the edge
   task automatic drive(input logic [NB_DATA-1:0] d, input logic am, input logic v, input logic en);
      i_data    = d;
      i_am_flag = am;
      i_valid   = v;
      i_enable  = en;
      @(posedge i_clock);
      #1;
      if (o_match || o_bip7_error || o_am_missing) strobe_seen++;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      drive('0, 1'b0, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0, 1'b0);
      i_reset = 1'b0;
   endtask

   task automatic zero_blocks(input int n, input int flip_at);
      for (int i = 0; i < n; i++)
         drive(make_block(8'h00, 8'h00, (i == flip_at) ? 10 : -1), 1'b0, 1'b1, 1'b1);
   endtask

   logic [NB_DATA-1:0] am_a, am_b, am_zero, am_ok;

   initial begin
      i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_am_flag = 1'b0; i_data = '0;
      am_a    = make_block(8'h5A, 8'hA5, -1);
      am_b    = make_block(8'h3C, 8'hC4, -1);
      am_zero = make_block(8'h00, 8'h00, -1);
      am_ok   = make_block(8'h00, 8'hFF, -1);
      #1;
      do_reset();
      check_value("rst_state", 32'(dut.state), 32'(WAIT_AM));
      check_value("rst_outs", {o_recived_bip, o_calculated_bip, 5'b0, o_match, o_bip7_error, o_am_missing}, 0);

      // 1: first AM opens a period without reporting; bip_of(am_a)=0x5A^0xA5^0x10
      drive(am_a, 1'b1, 1'b1, 1'b1);
      check_value("t1_no_match", o_match, 0);
      check_value("t1_state", 32'(dut.state), 32'(ACCUM));
      check_value("t1_cnt", 32'(dut.cnt), 0);
      check_value("t1_acc", 32'(dut.acc), 32'h0EF);

      // Back-to-back AM reports the first AM's parity; BIP7 consistent
      drive(am_a, 1'b1, 1'b1, 1'b1);
      check_value("b2b_match", o_match, 1);
      check_value("b2b_calc", o_calculated_bip, 32'hEF);
      check_value("b2b_recv", o_recived_bip, 32'h5A);
      check_value("b2b_bip7", o_bip7_error, 0);

      // 4: BIP7 0xC4 is not ~0x3C
      drive(am_b, 1'b1, 1'b1, 1'b1);
      check_value("t4_match", o_match, 1);
      check_value("t4_bip7", o_bip7_error, 1);
      check_value("t4_recv", o_recived_bip, 32'h3C);
      check_value("t4_calc", o_calculated_bip, 32'hEF);
      drive('0, 1'b0, 1'b0, 1'b1);
      check_value("t4_strobe_drop", {o_match, o_bip7_error}, 0);
      check_value("t4_hold_recv", o_recived_bip, 32'h3C);

      // 2: clean full period, odd number of SH=01 blocks cancels AM header parity
      do_reset();
      drive(am_zero, 1'b1, 1'b1, 1'b1);
      strobe_seen = 0;
      zero_blocks(AM_BLOCK_PERIOD - 1, -1);
      check_value("t2_no_strobe", strobe_seen, 0);
      drive(am_ok, 1'b1, 1'b1, 1'b1);
      check_value("t2_match", o_match, 1);
      check_value("t2_calc", o_calculated_bip, 32'h00);
      check_value("t2_recv", o_recived_bip, 32'h00);
      check_value("t2_bip7", o_bip7_error, 0);

      // 3: one flipped block bit 10 lands in BIP bit 0
      do_reset();
      drive(am_zero, 1'b1, 1'b1, 1'b1);
      zero_blocks(AM_BLOCK_PERIOD - 1, 777);
      drive(am_ok, 1'b1, 1'b1, 1'b1);
      check_value("t3_match", o_match, 1);
      check_value("t3_diff", o_calculated_bip ^ o_recived_bip, 32'h01);

      // 5: missing AM at the expected position
      do_reset();
      drive(am_zero, 1'b1, 1'b1, 1'b1);
      zero_blocks(AM_BLOCK_PERIOD - 1, -1);
      check_value("t5_cnt_last", 32'(dut.cnt), AM_BLOCK_PERIOD - 1);
      check_value("t5_not_yet", o_am_missing, 0);
      zero_blocks(1, -1);
      check_value("t5_missing", o_am_missing, 1);
      check_value("t5_state", 32'(dut.state), 32'(WAIT_AM));
      drive('0, 1'b0, 1'b0, 1'b1);
      check_value("t5_pulse_1cyc", o_am_missing, 0);
      drive(am_a, 1'b1, 1'b1, 1'b1);
      check_value("t5_am_no_match", o_match, 0);
      check_value("t5_rearm", 32'(dut.state), 32'(ACCUM));

      // 6: freeze then mid-period reset; acc after am_a + 3 SH=01 blocks = 0xEF^0x10 = 0xFF
      do_reset();
      drive(am_a, 1'b1, 1'b1, 1'b1);
      drive(am_a, 1'b1, 1'b1, 1'b1);
      zero_blocks(3, -1);
      strobe_seen = 0;
      for (int i = 0; i < 100; i++) drive(am_b, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) drive(am_b, 1'b1, 1'b0, 1'b1);
      check_value("t6_no_strobe", strobe_seen, 0);
      check_value("t6_cnt_frozen", 32'(dut.cnt), 3);
      check_value("t6_acc_frozen", 32'(dut.acc), 32'hFF);
      check_value("t6_recv_held", o_recived_bip, 32'h5A);
      i_reset = 1'b1;
      drive(am_b, 1'b1, 1'b1, 1'b1);
      i_reset = 1'b0;
      check_value("t6_rst_state", 32'(dut.state), 32'(WAIT_AM));
      check_value("t6_rst_outs", {o_recived_bip, o_calculated_bip, 5'b0, o_match, o_bip7_error, o_am_missing}, 0);
      check_value("t6_rst_cnt_acc", {dut.cnt, dut.acc}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
